tlb_ctrl: RTL and testbench

TLB_CTRL -- requirements
Module: tlb_ctrl

---
 rtl/tlb_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_tlb_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_ctrl.sv
// TLB lookup controller: arbitrates two requesters, drives TLB lookups, page walks, fills and flush sweeps.
// Optional macro TLB_CTRL_PERF_EN enables saturating hit/miss performance counters.
module tlb_ctrl #(
  parameter int unsigned NSETS    = 8,
  parameter int unsigned WALK_TMO = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       r0_req,
  input  logic [63:0]                r0_va,
  input  logic [11:0]                r0_pcid,
  output logic                       r0_gnt,
  output logic                       r0_rsp,
  input  logic                       r1_req,
  input  logic [63:0]                r1_va,
  input  logic [11:0]                r1_pcid,
  output logic                       r1_gnt,
  output logic                       r1_rsp,
  output logic [63:0]                rsp_pa,
  output logic                       rsp_fault,
  output logic                       tlb_lookup,
  output logic [63:0]                tlb_va,
  output logic [11:0]                tlb_pcid,
  input  logic [NSETS-1:0]           tlb_hit,
  input  logic [63:0]                tlb_pa,
  output logic                       tlb_fill,
  output logic [63:0]                tlb_fill_pa,
  output logic                       walk_req,
  output logic [63:0]                walk_va,
  output logic [11:0]                walk_pcid,
  input  logic                       walk_ack,
  input  logic [63:0]                walk_pa,
  input  logic                       walk_fault,
  input  logic                       flush_req,
  input  logic [11:0]                flush_pcid,
  output logic                       flush_busy,
  output logic                       tlb_inv,
  output logic [$clog2(NSETS)-1:0]   tlb_inv_set,
  output logic [11:0]                tlb_inv_pcid,
  output logic [31:0]                perf_hits,
  output logic [31:0]                perf_miss
);

  localparam int unsigned SET_W  = $clog2(NSETS);
  localparam int unsigned VA_W   = 64;
  localparam int unsigned PCID_W = 12;
  localparam int unsigned TMO_W  = 8;

  typedef enum logic [2:0] {IDLE, LOOKUP, WALK, FILL, RESP, FLUSH} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                pend_q, pend_d;
  logic [PCID_W-1:0]   fpcid_q, fpcid_d;
  logic                pick_r1;

  logic                r0_gnt_d, r1_gnt_d, r0_rsp_d, r1_rsp_d;
  logic [VA_W-1:0]     rsp_pa_d, tlb_va_d, tlb_fill_pa_d, walk_va_d;
  logic                rsp_fault_d, tlb_lookup_d, tlb_fill_d, walk_req_d;
  logic [PCID_W-1:0]   tlb_pcid_d, walk_pcid_d, inv_pcid_d;
  logic                busy_d, tlb_inv_d;
  logic [SET_W-1:0]    inv_set_d;

  // Round-robin: r1 wins only if r0 is idle or r0 was the last one granted
  assign pick_r1 = r1_req & (~r0_req | ~last_q);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    tmo_d         = tmo_q;
    pend_d        = pend_q;
    fpcid_d       = fpcid_q;
    r0_gnt_d      = 1'b0;
    r1_gnt_d      = 1'b0;
    r0_rsp_d      = 1'b0;
    r1_rsp_d      = 1'b0;
    tlb_lookup_d  = 1'b0;
    tlb_fill_d    = 1'b0;
    tlb_inv_d     = 1'b0;
    rsp_pa_d      = rsp_pa;
    rsp_fault_d   = rsp_fault;
    tlb_va_d      = tlb_va;
    tlb_pcid_d    = tlb_pcid;
    tlb_fill_pa_d = tlb_fill_pa;
    walk_req_d    = walk_req;
    walk_va_d     = walk_va;
    walk_pcid_d   = walk_pcid;
    busy_d        = flush_busy;
    inv_set_d     = tlb_inv_set;
    inv_pcid_d    = tlb_inv_pcid;

    // A flush arriving while a request is in flight is parked until IDLE
    if (flush_req && !pend_q && state_q != IDLE && state_q != FLUSH) begin
      pend_d  = 1'b1;
      fpcid_d = flush_pcid;
      busy_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_q || flush_req) begin
          state_d    = FLUSH;
          tlb_inv_d  = 1'b1;
          inv_set_d  = '0;
          inv_pcid_d = pend_q ? fpcid_q : flush_pcid;
          pend_d     = 1'b0;
          busy_d     = 1'b1;
        end else if (r0_req || r1_req) begin
          state_d      = LOOKUP;
          owner_d      = pick_r1;
          last_d       = pick_r1;
          r0_gnt_d     = ~pick_r1;
          r1_gnt_d     = pick_r1;
          tlb_va_d     = pick_r1 ? r1_va : r0_va;
          tlb_pcid_d   = pick_r1 ? r1_pcid : r0_pcid;
          tlb_lookup_d = 1'b1;
        end
      end
      LOOKUP: begin
        // First LOOKUP cycle carries the strobe; the hit vector arrives in the second
        if (!tlb_lookup) begin
          if (|tlb_hit) begin
            state_d     = RESP;
            rsp_pa_d    = tlb_pa;
            rsp_fault_d = 1'b0;
          end else begin
            state_d     = WALK;
            walk_req_d  = 1'b1;
            walk_va_d   = tlb_va;
            walk_pcid_d = tlb_pcid;
            tmo_d       = '0;
          end
        end
      end
      WALK: begin
        if (walk_ack) begin
          walk_req_d = 1'b0;
          tmo_d      = '0;
          if (walk_fault) begin
            state_d     = RESP;
            rsp_fault_d = 1'b1;
            rsp_pa_d    = '0;
          end else begin
            state_d       = FILL;
            tlb_fill_d    = 1'b1;
            tlb_fill_pa_d = walk_pa;
            rsp_pa_d      = walk_pa;
            rsp_fault_d   = 1'b0;
          end
        end else if (tmo_q == TMO_W'(WALK_TMO - 1)) begin
          state_d     = RESP;
          walk_req_d  = 1'b0;
          rsp_fault_d = 1'b1;
          rsp_pa_d    = '0;
          tmo_d       = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      FILL: state_d = RESP;
      RESP: begin
        state_d  = IDLE;
        r0_rsp_d = ~owner_q;
        r1_rsp_d = owner_q;
      end
      FLUSH: begin
        if (tlb_inv_set == SET_W'(NSETS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          tlb_inv_d = 1'b1;
          inv_set_d = tlb_inv_set + SET_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      tmo_q        <= '0;
      pend_q       <= 1'b0;
      fpcid_q      <= '0;
      r0_gnt       <= 1'b0;
      r1_gnt       <= 1'b0;
      r0_rsp       <= 1'b0;
      r1_rsp       <= 1'b0;
      rsp_pa       <= '0;
      rsp_fault    <= 1'b0;
      tlb_lookup   <= 1'b0;
      tlb_va       <= '0;
      tlb_pcid     <= '0;
      tlb_fill     <= 1'b0;
      tlb_fill_pa  <= '0;
      walk_req     <= 1'b0;
      walk_va      <= '0;
      walk_pcid    <= '0;
      flush_busy   <= 1'b0;
      tlb_inv      <= 1'b0;
      tlb_inv_set  <= '0;
      tlb_inv_pcid <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      tmo_q        <= tmo_d;
      pend_q       <= pend_d;
      fpcid_q      <= fpcid_d;
      r0_gnt       <= r0_gnt_d;
      r1_gnt       <= r1_gnt_d;
      r0_rsp       <= r0_rsp_d;
      r1_rsp       <= r1_rsp_d;
      rsp_pa       <= rsp_pa_d;
      rsp_fault    <= rsp_fault_d;
      tlb_lookup   <= tlb_lookup_d;
      tlb_va       <= tlb_va_d;
      tlb_pcid     <= tlb_pcid_d;
      tlb_fill     <= tlb_fill_d;
      tlb_fill_pa  <= tlb_fill_pa_d;
      walk_req     <= walk_req_d;
      walk_va      <= walk_va_d;
      walk_pcid    <= walk_pcid_d;
      flush_busy   <= busy_d;
      tlb_inv      <= tlb_inv_d;
      tlb_inv_set  <= inv_set_d;
      tlb_inv_pcid <= inv_pcid_d;
    end
  end

`ifdef TLB_CTRL_PERF_EN
  // Saturating hit/miss counters, bumped on the cycle the hit vector is judged
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits <= '0;
      perf_miss <= '0;
    end else if (state_q == LOOKUP && !tlb_lookup) begin
      if (|tlb_hit) begin
        if (perf_hits != 32'hFFFF_FFFF) perf_hits <= perf_hits + 32'd1;
      end else begin
        if (perf_miss != 32'hFFFF_FFFF) perf_miss <= perf_miss + 32'd1;
      end
    end
  end
`else
  assign perf_hits = '0;
  assign perf_miss = '0;
`endif

endmodule

// File: tb/tb_tlb_ctrl.sv
// Self-checking bench for tlb_ctrl: TLB and walker responders plus a response scoreboard.
module tb_tlb_ctrl;

  localparam int unsigned NSETS    = 8;
  localparam int unsigned WALK_TMO = 255;

  typedef struct packed {
    logic        owner;
    logic [63:0] pa;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r1_req;
  logic [63:0] r0_va, r1_va;
  logic [11:0] r0_pcid, r1_pcid;
  logic        r0_gnt, r1_gnt, r0_rsp, r1_rsp;
  logic [63:0] rsp_pa;
  logic        rsp_fault;
  logic        tlb_lookup;
  logic [63:0] tlb_va;
  logic [11:0] tlb_pcid;
  logic [NSETS-1:0] tlb_hit;
  logic [63:0] tlb_pa;
  logic        tlb_fill;
  logic [63:0] tlb_fill_pa;
  logic        walk_req;
  logic [63:0] walk_va;
  logic [11:0] walk_pcid;
  logic        walk_ack, walk_ack_m, walk_ack_man;
  logic [63:0] walk_pa;
  logic        walk_fault;
  logic        flush_req;
  logic [11:0] flush_pcid;
  logic        flush_busy, tlb_inv;
  logic [2:0]  tlb_inv_set;
  logic [11:0] tlb_inv_pcid;
  logic [31:0] perf_hits, perf_miss;

  logic [NSETS-1:0] cfg_hit = '0;
  logic [63:0]      cfg_pa = '0;
  int               cfg_walk_delay = -1;
  logic [63:0]      cfg_walk_pa = '0;
  logic             cfg_walk_fault = 1'b0;

  int          cyc = 0;
  int          fill_cnt = 0;
  int          walk_hi = 0;
  logic [63:0] last_fill_pa = '0;
  int          wcnt = 0;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign walk_ack   = walk_ack_m | walk_ack_man;
  assign walk_pa    = cfg_walk_pa;
  assign walk_fault = cfg_walk_fault;

  tlb_ctrl #(.NSETS(NSETS), .WALK_TMO(WALK_TMO)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_va(r0_va), .r0_pcid(r0_pcid), .r0_gnt(r0_gnt), .r0_rsp(r0_rsp),
    .r1_req(r1_req), .r1_va(r1_va), .r1_pcid(r1_pcid), .r1_gnt(r1_gnt), .r1_rsp(r1_rsp),
    .rsp_pa(rsp_pa), .rsp_fault(rsp_fault),
    .tlb_lookup(tlb_lookup), .tlb_va(tlb_va), .tlb_pcid(tlb_pcid),
    .tlb_hit(tlb_hit), .tlb_pa(tlb_pa),
    .tlb_fill(tlb_fill), .tlb_fill_pa(tlb_fill_pa),
    .walk_req(walk_req), .walk_va(walk_va), .walk_pcid(walk_pcid),
    .walk_ack(walk_ack), .walk_pa(walk_pa), .walk_fault(walk_fault),
    .flush_req(flush_req), .flush_pcid(flush_pcid), .flush_busy(flush_busy),
    .tlb_inv(tlb_inv), .tlb_inv_set(tlb_inv_set), .tlb_inv_pcid(tlb_inv_pcid),
    .perf_hits(perf_hits), .perf_miss(perf_miss)
  );

  // TLB model: answers each lookup strobe one cycle later
  always @(posedge clk) begin
    tlb_hit <= tlb_lookup ? cfg_hit : '0;
    tlb_pa  <= tlb_lookup ? cfg_pa : '0;
  end

  // Walker model: acks after cfg_walk_delay+1 cycles of walk_req; negative delay never acks
  always @(posedge clk) begin
    if (rst || !walk_req || walk_ack_m) begin
      walk_ack_m <= 1'b0;
      wcnt       <= 0;
    end else if (wcnt == cfg_walk_delay) begin
      walk_ack_m <= 1'b1;
      wcnt       <= 0;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tlb_fill) begin
      fill_cnt     <= fill_cnt + 1;
      last_fill_pa <= tlb_fill_pa;
    end
    if (walk_req) walk_hi <= walk_hi + 1;
  end

  task automatic issue(input bit side, input logic [63:0] va, input logic [11:0] pcid,
                       output bit got, output int gcyc);
    got  = 1'b0;
    gcyc = 0;
    if (side) begin r1_req = 1'b1; r1_va = va; r1_pcid = pcid; end
    else      begin r0_req = 1'b1; r0_va = va; r0_pcid = pcid; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((side ? r1_gnt : r0_gnt) === 1'b1) begin
        got  = 1'b1;
        gcyc = cyc;
        break;
      end
    end
    if (side) r1_req = 1'b0; else r0_req = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (r0_rsp === 1'b1 || r1_rsp === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; r0_req = 1'b0; r1_req = 1'b0; r0_va = '0; r1_va = '0;
    r0_pcid = '0; r1_pcid = '0; flush_req = 1'b0; flush_pcid = '0; walk_ack_man = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({r0_gnt, r1_gnt, r0_rsp, r1_rsp, tlb_lookup, tlb_fill, tlb_inv, walk_req, flush_busy, rsp_fault} !== 10'd0)
      begin errors++; $display("FAIL reset_strobes got=%b want=0", {r0_gnt, r1_gnt, r0_rsp, r1_rsp, tlb_lookup, tlb_fill, tlb_inv, walk_req, flush_busy, rsp_fault}); end
    checks++;
    if ({rsp_pa, tlb_va, walk_va} !== 192'd0)
      begin errors++; $display("FAIL reset_addr rsp_pa=%h tlb_va=%h walk_va=%h want 0", rsp_pa, tlb_va, walk_va); end
    checks++;
    if ({perf_hits, perf_miss} !== 64'd0)
      begin errors++; $display("FAIL reset_perf hits=%0d miss=%0d want 0", perf_hits, perf_miss); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hit;
    bit got; int gcyc; int w0; exp_t e;
    cfg_hit = 8'h01; cfg_pa = 64'h8000;
    e.owner = 1'b0; e.pa = 64'h8000; e.fault = 1'b0;
    exp_q.push_back(e);
    w0 = walk_hi;
    issue(1'b0, 64'h1000, 12'h000, got, gcyc);
    checks++;
    if (!got || tlb_lookup !== 1'b1 || tlb_va !== 64'h1000)
      begin errors++; $display("FAIL hit_grant got=%0b lookup=%b va=%h want 1 1 1000", got, tlb_lookup, tlb_va); end
    wait_rsp(20, got);
    checks++;
    if (!got || cyc - gcyc != 3)
      begin errors++; $display("FAIL hit_latency got=%0b cycles=%0d want 3", got, cyc - gcyc); end
    e = exp_q.pop_front();
    checks++;
    if ({r0_rsp, r1_rsp, rsp_pa, rsp_fault} !== {~e.owner, e.owner, e.pa, e.fault})
      begin errors++; $display("FAIL hit_rsp r0=%b r1=%b pa=%h fault=%b want pa=%h", r0_rsp, r1_rsp, rsp_pa, rsp_fault, e.pa); end
    checks++;
    if (walk_hi != w0)
      begin errors++; $display("FAIL hit_no_walk walk_cycles=%0d want 0", walk_hi - w0); end
  endtask

  task automatic test_miss_fill;
    bit got; int gcyc; int f0; exp_t e;
    cfg_hit = '0; cfg_walk_delay = 4; cfg_walk_pa = 64'h2000; cfg_walk_fault = 1'b0;
    e.owner = 1'b1; e.pa = 64'h2000; e.fault = 1'b0;
    exp_q.push_back(e);
    f0 = fill_cnt;
    issue(1'b1, 64'hFFFF_FFFF_FFFF_F000, 12'h0C3, got, gcyc);
    for (int i = 0; i < 10 && walk_req !== 1'b1; i++) @(negedge clk);
    checks++;
    if (walk_req !== 1'b1 || walk_va !== 64'hFFFF_FFFF_FFFF_F000 || walk_pcid !== 12'h0C3)
      begin errors++; $display("FAIL miss_walk req=%b va=%h pcid=%h", walk_req, walk_va, walk_pcid); end
    wait_rsp(40, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || {r0_rsp, r1_rsp, rsp_pa, rsp_fault} !== {~e.owner, e.owner, e.pa, e.fault})
      begin errors++; $display("FAIL miss_rsp got=%0b r1=%b pa=%h fault=%b want pa=%h", got, r1_rsp, rsp_pa, rsp_fault, e.pa); end
    checks++;
    if (fill_cnt - f0 != 1 || last_fill_pa !== 64'h2000 || walk_req !== 1'b0)
      begin errors++; $display("FAIL miss_fill fills=%0d pa=%h walk_req=%b want 1 2000 0", fill_cnt - f0, last_fill_pa, walk_req); end
  endtask

  task automatic test_back_to_back;
    bit got; exp_t e; bit want_r1; int bad;
    cfg_hit = 8'h04; cfg_pa = 64'hABC000;
    r0_req = 1'b1; r0_va = 64'h10; r0_pcid = 12'h1;
    r1_req = 1'b1; r1_va = 64'h20; r1_pcid = 12'h2;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      e.owner = 1'(k % 2); e.pa = 64'hABC000; e.fault = 1'b0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      want_r1 = 1'(k % 2);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (r0_gnt === 1'b1 || r1_gnt === 1'b1) begin got = 1'b1; break; end
      end
      if (!got || r1_gnt !== want_r1 || r0_gnt !== ~want_r1) bad++;
      wait_rsp(20, got);
      if (k == 3) begin r0_req = 1'b0; r1_req = 1'b0; end
      e = exp_q.pop_front();
      checks++;
      if (!got || {r0_rsp, r1_rsp, rsp_pa, rsp_fault} !== {~e.owner, e.owner, e.pa, e.fault})
        begin errors++; $display("FAIL b2b_rsp%0d r0=%b r1=%b pa=%h want owner=%b", k, r0_rsp, r1_rsp, rsp_pa, e.owner); end
    end
    checks++;
    if (bad != 0)
      begin errors++; $display("FAIL b2b_order bad_grants=%0d want 0", bad); end
  endtask

  task automatic test_flush_during_walk;
    bit got; int gcyc; exp_t e; int inv_n; int first_inv; bit busy_bad; bit order_bad; bit rsp_seen;
    inv_n = 0; first_inv = -1; busy_bad = 1'b0; order_bad = 1'b0; rsp_seen = 1'b0;
    cfg_hit = '0; cfg_walk_delay = 6; cfg_walk_pa = 64'h3000; cfg_walk_fault = 1'b0;
    e.owner = 1'b0; e.pa = 64'h3000; e.fault = 1'b0;
    exp_q.push_back(e);
    issue(1'b0, 64'h4000, 12'h00A, got, gcyc);
    for (int i = 0; i < 10 && walk_req !== 1'b1; i++) @(negedge clk);
    flush_req = 1'b1; flush_pcid = 12'h005;
    @(negedge clk);
    flush_req = 1'b0; flush_pcid = '0;
    checks++;
    if (flush_busy !== 1'b1 || tlb_inv !== 1'b0)
      begin errors++; $display("FAIL flush_accept busy=%b inv=%b want 1 0", flush_busy, tlb_inv); end
    for (int i = 0; i < 60 && inv_n < int'(NSETS); i++) begin
      @(negedge clk);
      if (flush_busy !== 1'b1) busy_bad = 1'b1;
      if ((r0_rsp === 1'b1 || r1_rsp === 1'b1) && exp_q.size() > 0) begin
        rsp_seen = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if ({r0_rsp, r1_rsp, rsp_pa, rsp_fault} !== {~e.owner, e.owner, e.pa, e.fault})
          begin errors++; $display("FAIL flush_walk_rsp pa=%h fault=%b want %h 0", rsp_pa, rsp_fault, e.pa); end
      end
      if (tlb_inv === 1'b1) begin
        if (!rsp_seen || tlb_inv_set !== 3'(inv_n) || tlb_inv_pcid !== 12'h005) order_bad = 1'b1;
        if (first_inv < 0) first_inv = cyc;
        inv_n++;
      end
    end
    checks++;
    if (!rsp_seen || inv_n != int'(NSETS) || order_bad || cyc - first_inv != int'(NSETS) - 1)
      begin errors++; $display("FAIL flush_sweep rsp=%0b inv=%0d order_bad=%0b span=%0d want 1 8 0 7", rsp_seen, inv_n, order_bad, cyc - first_inv); end
    checks++;
    if (busy_bad)
      begin errors++; $display("FAIL flush_busy_hold dropped=1 want 0"); end
    @(negedge clk);
    checks++;
    if (flush_busy !== 1'b0 || tlb_inv !== 1'b0)
      begin errors++; $display("FAIL flush_end busy=%b inv=%b want 0 0", flush_busy, tlb_inv); end
  endtask

  task automatic test_timeout;
    bit got; int gcyc; int w0; int f0; exp_t e; bit late_bad;
    late_bad = 1'b0;
    cfg_hit = '0; cfg_walk_delay = -1; cfg_walk_pa = 64'h7777_0000;
    e.owner = 1'b1; e.pa = 64'h0; e.fault = 1'b1;
    exp_q.push_back(e);
    w0 = walk_hi;
    issue(1'b1, 64'h5000, 12'h0EE, got, gcyc);
    wait_rsp(400, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || {r0_rsp, r1_rsp, rsp_pa, rsp_fault} !== {~e.owner, e.owner, e.pa, e.fault})
      begin errors++; $display("FAIL tmo_rsp got=%0b r1=%b pa=%h fault=%b want 1 0 1", got, r1_rsp, rsp_pa, rsp_fault); end
    checks++;
    if (walk_hi - w0 != int'(WALK_TMO))
      begin errors++; $display("FAIL tmo_cycles walk_cycles=%0d want %0d", walk_hi - w0, WALK_TMO); end
    f0 = fill_cnt;
    walk_ack_man = 1'b1;
    @(negedge clk);
    walk_ack_man = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (r0_rsp === 1'b1 || r1_rsp === 1'b1 || walk_req === 1'b1) late_bad = 1'b1;
    end
    checks++;
    if (fill_cnt != f0 || late_bad)
      begin errors++; $display("FAIL tmo_late_ack fills=%0d spurious=%0b want 0 0", fill_cnt - f0, late_bad); end
  endtask

  task automatic test_reset_mid_walk;
    bit got; int gcyc; int f0; bit bad;
    bad = 1'b0;
    cfg_hit = '0; cfg_walk_delay = -1;
    issue(1'b1, 64'h6000, 12'h001, got, gcyc);
    for (int i = 0; i < 10 && walk_req !== 1'b1; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (walk_req !== 1'b0 || walk_va !== 64'h0)
      begin errors++; $display("FAIL rst_walk walk_req=%b walk_va=%h want 0 0", walk_req, walk_va); end
    f0 = fill_cnt;
    walk_ack_man = 1'b1;
    @(negedge clk);
    walk_ack_man = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (r0_rsp === 1'b1 || r1_rsp === 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || fill_cnt != f0)
      begin errors++; $display("FAIL rst_walk_quiet rsp=%0b fills=%0d want 0 0", bad, fill_cnt - f0); end
    // Both requesting after reset: r0 must win
    cfg_hit = 8'h02; cfg_pa = 64'h9000;
    r1_req = 1'b1; r1_va = 64'h1; r1_pcid = '0;
    issue(1'b0, 64'h2, 12'h0, got, gcyc);
    r1_req = 1'b0;
    checks++;
    if (!got || r1_gnt !== 1'b0)
      begin errors++; $display("FAIL rst_rr_first r0_got=%0b r1_gnt=%b want 1 0", got, r1_gnt); end
    wait_rsp(20, got);
  endtask

  task automatic test_perf;
    bit got; int gcyc; int f0; exp_t e; int exp_h; int exp_m;
    logic [NSETS-1:0] hv[5];
    hv[0] = 8'h01; hv[1] = 8'h81; hv[2] = 8'h80; hv[3] = 8'h00; hv[4] = 8'h00;
`ifdef TLB_CTRL_PERF_EN
    exp_h = 3; exp_m = 2;
`else
    exp_h = 0; exp_m = 0;
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    f0 = fill_cnt;
    cfg_walk_delay = 0; cfg_walk_fault = 1'b1; cfg_walk_pa = 64'hDEAD_0000;
    for (int k = 0; k < 5; k++) begin
      cfg_hit = hv[k];
      cfg_pa  = 64'h1_0000 + 64'(k);
      e.owner = 1'(k % 2);
      e.pa    = (k < 3) ? 64'h1_0000 + 64'(k) : 64'h0;
      e.fault = (k >= 3);
      exp_q.push_back(e);
      issue(1'(k % 2), 64'h100 * 64'(k), 12'(k), got, gcyc);
      wait_rsp(40, got);
      e = exp_q.pop_front();
      checks++;
      if (!got || {r0_rsp, r1_rsp, rsp_pa, rsp_fault} !== {~e.owner, e.owner, e.pa, e.fault})
        begin errors++; $display("FAIL perf_rsp%0d got=%0b pa=%h fault=%b want %h %b", k, got, rsp_pa, rsp_fault, e.pa, e.fault); end
    end
    checks++;
    if (fill_cnt != f0)
      begin errors++; $display("FAIL fault_no_fill fills=%0d want 0", fill_cnt - f0); end
    checks++;
    if (perf_hits !== 32'(exp_h) || perf_miss !== 32'(exp_m))
      begin errors++; $display("FAIL perf_count hits=%0d miss=%0d want %0d %0d", perf_hits, perf_miss, exp_h, exp_m); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (perf_hits !== 32'd0 || perf_miss !== 32'd0)
      begin errors++; $display("FAIL perf_clear hits=%0d miss=%0d want 0 0", perf_hits, perf_miss); end
    cfg_walk_fault = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss_fill();
    test_back_to_back();
    test_flush_during_walk();
    test_timeout();
    test_reset_mid_walk();
    test_perf();
    checks++;
    if (exp_q.size() != 0)
      begin errors++; $display("FAIL scoreboard_leftover entries=%0d want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
